// File: rtl/im2col_stream.sv
// im2col_stream
//   Buffers a CHANNELS x IN_H x IN_W feature map written element by element,
//   then streams one flattened KERNEL x KERNEL patch per output position with
//   stride and zero padding. The order is channel innermost, then x, then y.
//   Each patch goes out through a valid/ready handshake.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   write_en/x/y/c  element write into the buffer (ignored while busy)
//   write_data      element value
//   start           begin a frame (sampled in IDLE only)
//   busy            frame in progress (LOAD/OUTPUT)
//   done            one-cycle pulse after the final patch handshake
//   out_valid       patch available; out_ready accepts it
//   out_data        patch, element (i*K+j) at [(i*K+j)*DWIDTH +: DWIDTH]
//   out_x/y/c       output position and channel of the patch
//   out_last        final patch of the frame
module im2col_stream #(
   parameter int IN_W     = 8,
   parameter int IN_H     = 8,
   parameter int CHANNELS = 2,
   parameter int KERNEL   = 3,
   parameter int STRIDE   = 1,
   parameter int PAD      = 1,
   parameter int DWIDTH   = 8,
   localparam int XW = (IN_W > 1) ? $clog2(IN_W) : 1,
   localparam int YW = (IN_H > 1) ? $clog2(IN_H) : 1,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int PW = DWIDTH * KERNEL * KERNEL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_en,
   input  logic [XW-1:0]     write_x,
   input  logic [YW-1:0]     write_y,
   input  logic [CW-1:0]     write_c,
   input  logic [DWIDTH-1:0] write_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PW-1:0]     out_data,
   output logic [15:0]       out_x,
   output logic [15:0]       out_y,
   output logic [15:0]       out_c,
   output logic              out_last
);

   localparam int OUT_W = (IN_W + 2*PAD - KERNEL) / STRIDE + 1;
   localparam int OUT_H = (IN_H + 2*PAD - KERNEL) / STRIDE + 1;
   localparam int MAXD  = (IN_W > IN_H) ? IN_W : IN_H;
   // Two spare bits: one for sign, one of headroom, so -PAD never aliases.
   localparam int CRDW  = $clog2(MAXD + 2*PAD) + 2;

   localparam logic signed [CRDW-1:0] STRIDE_S = CRDW'(STRIDE);
   localparam logic signed [CRDW-1:0] PAD_S    = CRDW'(PAD);
   localparam logic signed [CRDW-1:0] IN_W_S   = CRDW'(IN_W);
   localparam logic signed [CRDW-1:0] IN_H_S   = CRDW'(IN_H);
   localparam logic [CRDW-1:0]        LAST_X   = CRDW'(OUT_W - 1);
   localparam logic [CRDW-1:0]        LAST_Y   = CRDW'(OUT_H - 1);
   localparam logic [CW-1:0]          LAST_C   = CW'(CHANNELS - 1);
   localparam logic [XW:0]            IN_W_U   = IN_W[XW:0];
   localparam logic [YW:0]            IN_H_U   = IN_H[YW:0];
   localparam logic [CW:0]            CH_U     = CHANNELS[CW:0];

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUTPUT, S_DONE} state_t;

   state_t            state;
   logic [CRDW-1:0]   cnt_x, cnt_y;
   logic [CW-1:0]     cnt_c;
   logic              is_last;
   logic [PW-1:0]     patch_p0;
   logic [DWIDTH-1:0] mem [CHANNELS][IN_H][IN_W];

   assign out_x   = 16'(cnt_x);
   assign out_y   = 16'(cnt_y);
   assign out_c   = 16'(cnt_c);
   assign is_last = (cnt_x == LAST_X) && (cnt_y == LAST_Y) && (cnt_c == LAST_C);

   // Buffer is frozen while a frame is being streamed.
   always_ff @(posedge clk) begin
      if (write_en && !busy && ({1'b0, write_x} < IN_W_U) &&
          ({1'b0, write_y} < IN_H_U) && ({1'b0, write_c} < CH_U))
         mem[write_c][write_y][write_x] <= write_data;
   end

   // ---- stage p0: gather the padded window for (cnt_x, cnt_y, cnt_c) ----
   always_comb begin : gather
      logic signed [CRDW-1:0] row;
      logic signed [CRDW-1:0] col;
      patch_p0 = '0;
      row      = '0;
      col      = '0;
      for (int i = 0; i < KERNEL; i++) begin
         for (int j = 0; j < KERNEL; j++) begin
            row = $signed(cnt_y) * STRIDE_S + CRDW'(i) - PAD_S;
            col = $signed(cnt_x) * STRIDE_S + CRDW'(j) - PAD_S;
            if (!row[CRDW-1] && (row < IN_H_S) && !col[CRDW-1] && (col < IN_W_S))
               patch_p0[(i*KERNEL+j)*DWIDTH +: DWIDTH] =
                  mem[cnt_c][row[YW-1:0]][col[XW-1:0]];
         end
      end
   end

   // ---- stage p1: control FSM, patch register and handshake ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         cnt_x     <= '0;
         cnt_y     <= '0;
         cnt_c     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  cnt_x <= '0;
                  cnt_y <= '0;
                  cnt_c <= '0;
                  busy  <= 1'b1;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               out_data  <= patch_p0;
               out_last  <= is_last;
               out_valid <= 1'b1;
               state     <= S_OUTPUT;
            end
            S_OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (is_last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     // Channel innermost, then x, then y.
                     if (cnt_c == LAST_C) begin
                        cnt_c <= '0;
                        if (cnt_x == LAST_X) begin
                           cnt_x <= '0;
                           cnt_y <= cnt_y + 1'b1;
                        end else begin
                           cnt_x <= cnt_x + 1'b1;
                        end
                     end else begin
                        cnt_c <= cnt_c + 1'b1;
                     end
                     state <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_im2col_stream.sv
module tb_im2col_stream;
   localparam int IN_W = 5, IN_H = 4, CHANNELS = 2, KERNEL = 3, STRIDE = 2, PAD = 1, DWIDTH = 8;
   localparam int OUT_W = (IN_W + 2*PAD - KERNEL) / STRIDE + 1;
   localparam int OUT_H = (IN_H + 2*PAD - KERNEL) / STRIDE + 1;
   localparam int TOTAL = OUT_W * OUT_H * CHANNELS;
   localparam int XW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int YW = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PW = DWIDTH * KERNEL * KERNEL;

   typedef struct {int x; int y; int c;} pos_t;

   logic clk = 1'b0, rst = 1'b0, write_en = 1'b0, start = 1'b0, out_ready = 1'b0;
   logic [XW-1:0] write_x = '0;
   logic [YW-1:0] write_y = '0;
   logic [CW-1:0] write_c = '0;
   logic [DWIDTH-1:0] write_data = '0;
   logic busy, done, out_valid, out_last;
   logic [PW-1:0] out_data;
   logic [15:0] out_x, out_y, out_c;

   int   ref_mem [CHANNELS][IN_H][IN_W];
   pos_t order[$];
   int   tests = 0, fails = 0;

   im2col_stream #(.IN_W(IN_W), .IN_H(IN_H), .CHANNELS(CHANNELS), .KERNEL(KERNEL),
                   .STRIDE(STRIDE), .PAD(PAD), .DWIDTH(DWIDTH)) dut (
      .clk(clk), .rst(rst), .write_en(write_en), .write_x(write_x), .write_y(write_y),
      .write_c(write_c), .write_data(write_data), .start(start), .busy(busy), .done(done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_x(out_x),
      .out_y(out_y), .out_c(out_c), .out_last(out_last));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: window element (i,j) of output (px,py) reads input pixel
   // (py*STRIDE+i-PAD, px*STRIDE+j-PAD); anything off the map is zero.
   function automatic logic [PW-1:0] exp_patch(int px, int py, int pc);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < KERNEL; i++)
         for (int j = 0; j < KERNEL; j++) begin
            int r, cc;
            r  = py * STRIDE + i - PAD;
            cc = px * STRIDE + j - PAD;
            if (r >= 0 && r < IN_H && cc >= 0 && cc < IN_W)
               p[(i*KERNEL+j)*DWIDTH +: DWIDTH] = DWIDTH'(ref_mem[pc][r][cc]);
         end
      return p;
   endfunction

   task automatic build_order();
      pos_t p;
      order.delete();
      for (int y = 0; y < OUT_H; y++)
         for (int x = 0; x < OUT_W; x++)
            for (int c = 0; c < CHANNELS; c++) begin
               p.x = x; p.y = y; p.c = c;
               order.push_back(p);
            end
   endtask

   // pattern 0: coordinate-coded, 1: random non-zero, 2: random full range
   task automatic load_map(input int pattern);
      for (int c = 0; c < CHANNELS; c++)
         for (int y = 0; y < IN_H; y++)
            for (int x = 0; x < IN_W; x++) begin
               int v;
               if (pattern == 0)      v = c * 100 + y * IN_W + x;
               else if (pattern == 1) v = int'($urandom_range(1, 255));
               else                   v = int'($urandom_range(0, 255));
               ref_mem[c][y][x] = v;
               write_en = 1'b1; write_x = XW'(x); write_y = YW'(y); write_c = CW'(c);
               write_data = DWIDTH'(v);
               tick();
            end
      write_en = 1'b0;
   endtask

   // ready_mode 0: always ready, 1: random, 2: hold 5 cycles on first patch then random.
   // noise: random starts and 0xFF writes while busy. abort_at: patch index at which
   // rst is pulsed (-1 = none). start_in_done: pulse start during the DONE cycle.
   task automatic run_frame(input int ready_mode, input bit noise, input int abort_at,
                            input bit start_in_done, input string tag);
      int idx, cyc, held;
      bit expect_valid, prev_hs, stall_prev, aborted;
      logic [PW-1:0] ep;
      idx = 0; cyc = 0; held = 0;
      expect_valid = 1'b0; prev_hs = 1'b0; stall_prev = 1'b0; aborted = 1'b0;
      out_ready = (ready_mode == 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL %s start_to_load: valid=%b busy=%b done=%b, required 0 1 0", tag, out_valid, busy, done);
      end
      expect_valid = 1'b1;
      while (idx < TOTAL && !aborted && cyc < 400) begin
         tick();
         cyc++;
         if (prev_hs) begin
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
               fails++;
               $display("FAIL %s load_gap idx=%0d: valid=%b busy=%b, required 0 1", tag, idx, out_valid, busy);
            end
            prev_hs = 1'b0;
            expect_valid = 1'b1;
         end else if (expect_valid || stall_prev) begin
            tests++;
            if (out_valid !== 1'b1) begin
               fails++;
               $display("FAIL %s valid_rise idx=%0d: valid=%b, required 1", tag, idx, out_valid);
            end
            expect_valid = 1'b0;
         end
         tests++;
         if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s early_done idx=%0d: done=%b, required 0", tag, idx, done);
         end
         if (out_valid === 1'b1) begin
            ep = exp_patch(order[idx].x, order[idx].y, order[idx].c);
            tests++;
            if (out_data !== ep) begin
               fails++;
               $display("FAIL %s data idx=%0d: got %h, required %h", tag, idx, out_data, ep);
            end
            tests++;
            if (out_x !== 16'(order[idx].x) || out_y !== 16'(order[idx].y) ||
                out_c !== 16'(order[idx].c) || busy !== 1'b1) begin
               fails++;
               $display("FAIL %s position idx=%0d: got x=%0d y=%0d c=%0d busy=%b, required x=%0d y=%0d c=%0d busy=1",
                        tag, idx, out_x, out_y, out_c, busy, order[idx].x, order[idx].y, order[idx].c);
            end
            tests++;
            if (out_last !== 1'(idx == TOTAL - 1)) begin
               fails++;
               $display("FAIL %s last idx=%0d: got %b, required %b", tag, idx, out_last, idx == TOTAL - 1);
            end
         end
         if (out_valid === 1'b1 && idx == abort_at) begin
            start = 1'b0; write_en = 1'b0; out_ready = 1'b0;
            rst = 1'b1;
            #1;
            tests++;
            if ({out_valid, busy, done, out_last} !== 4'b0000) begin
               fails++;
               $display("FAIL %s reset_immediate: valid,busy,done,last=%b, required 0000", tag, {out_valid, busy, done, out_last});
            end
            tick();
            tests++;
            if ({out_valid, busy, done} !== 3'b000) begin
               fails++;
               $display("FAIL %s reset_next_cycle: valid,busy,done=%b, required 000", tag, {out_valid, busy, done});
            end
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
               tick();
               tests++;
               if ({out_valid, busy, done} !== 3'b000) begin
                  fails++;
                  $display("FAIL %s reset_no_done k=%0d: valid,busy,done=%b, required 000", tag, k, {out_valid, busy, done});
               end
            end
            aborted = 1'b1;
         end else begin
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 2 && idx == 0 && out_valid === 1'b1 && held < 5) begin
               out_ready = 1'b0;
               held++;
            end else out_ready = 1'($urandom_range(0, 1));
            stall_prev = (out_valid === 1'b1) && !out_ready;
            if (out_valid === 1'b1 && out_ready) begin
               idx++;
               prev_hs = 1'b1;
            end
            if (noise && busy === 1'b1) begin
               write_en   = 1'($urandom_range(0, 1));
               write_x    = XW'($urandom_range(0, IN_W - 1));
               write_y    = YW'($urandom_range(0, IN_H - 1));
               write_c    = CW'($urandom_range(0, CHANNELS - 1));
               write_data = 8'hFF;
               start      = (idx < TOTAL) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
               write_en = 1'b0;
               start    = 1'b0;
            end
         end
      end
      if (aborted) return;
      if (idx < TOTAL) begin
         tests++; fails++;
         $display("FAIL %s timeout: %0d patches seen, required %0d", tag, idx, TOTAL);
         start = 1'b0; write_en = 1'b0; out_ready = 1'b0;
         return;
      end
      tick();
      write_en = 1'b0; out_ready = 1'b0; start = start_in_done;
      tests++;
      if ({done, busy, out_valid, out_last} !== 4'b1000) begin
         fails++;
         $display("FAIL %s done_state: done,busy,valid,last=%b, required 1000", tag, {done, busy, out_valid, out_last});
      end
      tick();
      start = 1'b0;
      tests++;
      if ({done, busy, out_valid} !== 3'b000) begin
         fails++;
         $display("FAIL %s done_single_pulse: done,busy,valid=%b, required 000", tag, {done, busy, out_valid});
      end
      tick();
      tests++;
      if ({done, busy, out_valid} !== 3'b000) begin
         fails++;
         $display("FAIL %s idle_after_done: done,busy,valid=%b, required 000", tag, {done, busy, out_valid});
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({busy, done, out_valid, out_last} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: busy,done,valid,last=%b, required 0000", {busy, done, out_valid, out_last});
      end
      tests++;
      if (out_data !== '0 || out_x !== 16'd0 || out_y !== 16'd0 || out_c !== 16'd0) begin
         fails++;
         $display("FAIL reset_data: data=%h x=%0d y=%0d c=%0d, required all 0", out_data, out_x, out_y, out_c);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      tests++;
      if ({busy, done, out_valid} !== 3'b000) begin
         fails++;
         $display("FAIL reset_idle: busy,done,valid=%b, required 000", {busy, done, out_valid});
      end
   endtask

   task automatic test_basic();
      load_map(0);
      run_frame(0, 1'b0, -1, 1'b0, "basic");
   endtask

   task automatic test_padding_random();
      for (int n = 0; n < 2; n++) begin
         load_map(1);
         run_frame(0, 1'b0, -1, 1'b0, "padding");
      end
   endtask

   task automatic test_backpressure();
      load_map(1);
      run_frame(2, 1'b1, -1, 1'b0, "backpressure");
      run_frame(0, 1'b0, -1, 1'b0, "frozen_buffer");
   endtask

   task automatic test_random_ready();
      for (int n = 0; n < 3; n++) begin
         load_map(2);
         run_frame(1, 1'b1, -1, 1'b0, "random_ready");
      end
   endtask

   task automatic test_back_to_back();
      run_frame(0, 1'b0, -1, 1'b1, "start_in_done");
      run_frame(1, 1'b0, -1, 1'b0, "back_to_back");
   endtask

   task automatic test_reset_midframe();
      load_map(1);
      run_frame(1, 1'b0, 2, 1'b0, "reset_mid");
      run_frame(0, 1'b0, -1, 1'b0, "after_reset");
   endtask

   initial begin
      build_order();
      test_reset();
      test_basic();
      test_padding_random();
      test_backpressure();
      test_random_ready();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/im2col_stream.md
Name: im2col_stream

Overview:
- Parametrised next-generation im2col. Buffers a multi-channel input feature map in on-chip memory and streams flattened KxK patches to the systolic-array feeder.
- Adds stride, zero padding, channel count and a valid/ready output handshake with backpressure.
- Sits between the activation loader (write port) and the matrix-multiply input staging.

Parameters:
IN_W, 8, input feature-map width (pixels)
IN_H, 8, input feature-map height (pixels)
CHANNELS, 2, number of input channels
KERNEL, 3, square kernel size K
STRIDE, 1, window step in x and y (>=1)
PAD, 1, zero-padding border width on all four sides (0..KERNEL-1)
DWIDTH, 8, bits per element

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
write_en  in  1  write one element into buffer
write_x  in  $clog2(IN_W)  column of element
write_y  in  $clog2(IN_H)  row of element
write_c  in  $clog2(CHANNELS) (min 1)  channel of element
write_data  in  DWIDTH  element value
start  in  1  begin patch generation (sampled in IDLE only)
busy  out  1  high from accepted start until the cycle done pulses
done  out  1  one-cycle pulse after last patch handshake
out_valid  out  1  patch available
out_ready  in  1  downstream accepts patch
out_data  out  DWIDTH*KERNEL*KERNEL  flattened patch; element (i*K+j) at bits [(i*K+j)*DWIDTH +: DWIDTH], i = kernel row, j = kernel col
out_x  out  16  output column index of patch
out_y  out  16  output row index of patch
out_c  out  16  channel of patch
out_last  out  1  high with the final patch of the frame

Behaviour:
- OUT_W = (IN_W + 2*PAD - KERNEL)/STRIDE + 1 (integer floor); OUT_H likewise. Total patches = OUT_W*OUT_H*CHANNELS.
- Reset: state IDLE; busy, done, out_valid and out_last = 0; out_data, out_x, out_y and out_c = 0. Buffer contents are not reset.
- Writes are accepted only when busy=0. write_en while busy is ignored, so buffer contents stay frozen for the frame.
- FSM states:
  - IDLE: start -> LOAD. Counters x, y and c are cleared. busy rises on the cycle after start.
  - LOAD: one cycle. Registers the patch for the current (x,y,c) into out_data. Element (i,j) reads buffer[c][y*STRIDE+i-PAD][x*STRIDE+j-PAD]. Any coordinate outside 0..IN_H-1 / 0..IN_W-1 yields 0. Then -> OUTPUT.
  - OUTPUT: out_valid=1. out_data, out_x, out_y, out_c and out_last are held stable while out_ready=0.
    - On out_valid && out_ready, if this is the last patch -> DONE.
    - Otherwise advance and -> LOAD.
  - DONE: one cycle, done=1, busy=0, out_valid=0 -> IDLE.
- Iteration order: channel innermost, then x, then y. Example for (x=0,y=0): c=0..CHANNELS-1, then x=1, and so on.
- out_last = 1 only during OUTPUT of patch (OUT_W-1, OUT_H-1, CHANNELS-1).
- Latency:
  - start (IDLE) -> first out_valid: 2 clock edges (IDLE->LOAD->OUTPUT).
  - Handshake -> next out_valid: 2 cycles.
  - Peak rate is 1 patch per 2 cycles.
- start while busy or in DONE is ignored.
- out_ready may be held high permanently. out_valid never depends combinationally on out_ready.
- Async reset mid-frame returns to IDLE immediately and drops out_valid. No done pulse is generated. The next start begins a full frame from (0,0,0).
- Coordinate arithmetic uses signed intermediate values at least $clog2(max(IN_W,IN_H)+2*PAD)+2 bits wide, so negative padded indices are never aliased into valid addresses.

Test Plan:
- IN 4x4, CHANNELS=1, K=3, STRIDE=1, PAD=0, data=y*4+x; start with out_ready=1:
  - Expect 4 patches.
  - First patch elements 0..8 = {0,1,2,4,5,6,8,9,10}.
  - Last patch = {5,6,7,9,10,11,13,14,15} with out_last=1.
  - done pulses once; busy falls.
- Same map with PAD=1:
  - OUT 4x4 = 16 patches.
  - Patch (0,0) = {0,0,0,0,0,1,0,4,5}.
  - Patch (3,3) = {10,11,0,14,15,0,0,0,0}.
- IN 5x5, PAD=0, STRIDE=2, data=y*5+x:
  - 4 patches.
  - Patch (1,0) = {2,3,4,7,8,9,12,13,14}.
  - Patch (1,1) has element 8 = 24.
- CHANNELS=2, ch1 data=100+y*4+x, 4x4, PAD=0:
  - Order is (0,0,c0), (0,0,c1), (1,0,c0)...
  - Second patch element 0 = 100; out_c toggles 0,1.
- Backpressure: hold out_ready=0 for 5 cycles on the first patch.
  - out_valid stays 1 and out_data is unchanged.
  - No patch is skipped or duplicated.
  - write_en with data 0xFF during busy does not alter later patches.
- Assert rst during the 3rd patch.
  - Next cycle: out_valid=0, busy=0, and no done pulse.
  - A new start reproduces the first patch exactly.
